// File: rtl/target_gen_multi.sv
// Target placement engine: draws LFSR candidates and publishes the first legal, unobstructed cell.
// Build option: define TARGET_GEN_OCC_CHECK_EN to add the WAIT_OCC snake-occupancy stage.
module target_gen_multi #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int X_MIN     = 1,
    parameter int X_MAX     = 158,
    parameter int Y_MIN     = 1,
    parameter int Y_MAX     = 118,
    parameter int N_BLOCK   = 4,
    parameter int RESET_X   = 55,
    parameter int RESET_Y   = 13,
    parameter int MAX_TRIES = 16,
    parameter logic [X_W+Y_W-1:0] LFSR_SEED = 15'h5A5A
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         Reached_Target,
    input  logic [N_BLOCK*(X_W+Y_W)-1:0] Block_Address,
    output logic [X_W+Y_W-1:0]           Occ_Query_Address,
    input  logic                         Occ_Hit,
    output logic [X_W+Y_W-1:0]           Random_Target_Address,
    output logic                         Target_Valid,
    output logic                         Busy,
    output logic                         Fallback_Used
);

    localparam int AW    = X_W + Y_W;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [X_W-1:0]   X_LO      = X_W'(X_MIN);
    localparam logic [X_W-1:0]   X_HI      = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   Y_LO      = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0]   Y_HI      = Y_W'(Y_MAX);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
    localparam logic [AW-1:0]    FALLBACK_ADDR = {X_W'(RESET_X), Y_W'(RESET_Y)};

    // Right-shift Galois masks for maximal-length sequences, indexed by register width.
    function automatic logic [31:0] galois_taps(input int w);
        case (w)
            8:       galois_taps = 32'h0000_00B8;
            9:       galois_taps = 32'h0000_0110;
            10:      galois_taps = 32'h0000_0240;
            11:      galois_taps = 32'h0000_0500;
            12:      galois_taps = 32'h0000_0E08;
            13:      galois_taps = 32'h0000_1C80;
            14:      galois_taps = 32'h0000_3802;
            15:      galois_taps = 32'h0000_6000;
            16:      galois_taps = 32'h0000_D008;
            17:      galois_taps = 32'h0001_2000;
            18:      galois_taps = 32'h0002_0400;
            19:      galois_taps = 32'h0007_2000;
            20:      galois_taps = 32'h0009_0000;
            default: galois_taps = 32'h0000_0000;
        endcase
    endfunction

    localparam logic [31:0]   TAPS32 = galois_taps(AW);
    localparam logic [AW-1:0] TAPS   = TAPS32[AW-1:0];

`ifdef TARGET_GEN_OCC_CHECK_EN
    typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, WAIT_OCC, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, DONE} state_t;
`endif

    state_t           state, state_nxt;
    logic [AW-1:0]    lfsr, lfsr_step;
    logic [AW-1:0]    cand;
    logic [TRY_W-1:0] tries;
    logic             fallback;
    logic             on_block, off_box, cand_bad, tries_left, reject, exhausted;
    logic [X_W-1:0]   cand_x;
    logic [Y_W-1:0]   cand_y;

`ifdef TARGET_GEN_OCC_CHECK_EN
    logic bad_q;
`else
    logic unused_occ_hit;
    assign unused_occ_hit = Occ_Hit;
`endif

    assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

    assign cand_x     = cand[AW-1:Y_W];
    assign cand_y     = cand[Y_W-1:0];
    assign off_box    = (cand_x < X_LO) || (cand_x > X_HI) || (cand_y < Y_LO) || (cand_y > Y_HI);
    assign cand_bad   = off_box || on_block;
    assign tries_left = (tries < TRY_LIMIT);
    assign exhausted  = reject && !tries_left;
    assign Busy       = (state != IDLE);

    always_comb begin
        on_block = 1'b0;
        for (int k = 0; k < N_BLOCK; k++)
            if (cand == Block_Address[k*AW +: AW]) on_block = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        reject    = 1'b0;
        unique case (state)
            IDLE:     if (Reached_Target) state_nxt = SAMPLE;
            SAMPLE:   state_nxt = CHECK;
`ifdef TARGET_GEN_OCC_CHECK_EN
            // Obstacle/box verdict is carried into WAIT_OCC so every reject costs the same.
            CHECK:    state_nxt = WAIT_OCC;
            WAIT_OCC: begin
                reject    = bad_q || Occ_Hit;
                state_nxt = DONE;
            end
`else
            CHECK:    begin
                reject    = cand_bad;
                state_nxt = DONE;
            end
`endif
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (reject && tries_left) state_nxt = SAMPLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state                 <= IDLE;
            lfsr                  <= LFSR_SEED;
            tries                 <= '0;
            fallback              <= 1'b0;
            Random_Target_Address <= FALLBACK_ADDR;
            Occ_Query_Address     <= '0;
            Target_Valid          <= 1'b0;
            Fallback_Used         <= 1'b0;
        end else begin
            state         <= state_nxt;
            lfsr          <= (lfsr_step == '0) ? LFSR_SEED : lfsr_step;
            Target_Valid  <= 1'b0;
            Fallback_Used <= 1'b0;
            if (state == IDLE && Reached_Target) begin
                tries    <= '0;
                fallback <= 1'b0;
            end
            if (state == SAMPLE) tries <= tries + 1'b1;
            if (state == CHECK) Occ_Query_Address <= cand;
            if (exhausted) fallback <= 1'b1;
            if (state == DONE) begin
                Random_Target_Address <= fallback ? FALLBACK_ADDR : cand;
                Target_Valid          <= 1'b1;
                Fallback_Used         <= fallback;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (state == SAMPLE) cand <= lfsr;
`ifdef TARGET_GEN_OCC_CHECK_EN
        if (state == CHECK) bad_q <= cand_bad;
`endif
    end

endmodule
